axis_pattern_source: RTL and testbench

Synthesizable AXI-stream transmitter that emits a deterministic packet of counting subwords ending in tlast, with optional pseudo-random valid gaps. It is the on-chip source counterpart to the stream receivers used to exercise stream-processing blocks such as the width converters. It lets hardware loopback tests drive those blocks without a host-side source. Downstream checkers can recompute every subword from its index alone.

---
 rtl/axis_pattern_source_if.sv | 19 +
 rtl/axis_pattern_source.sv | 161 ++++++++++++++++
 tb/tb_axis_pattern_source.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/axis_pattern_source_if.sv
// Axis_If: AXI-stream style bundle carrying one data word per transfer.
//   data/valid/last : driven by the master (source)
//   ready           : driven by the slave (sink)
//   ok              : transfer qualifier, valid && ready, computed here
interface Axis_If #(
    parameter int unsigned DWIDTH = 48
);
    logic [DWIDTH-1:0] data;
    logic              valid;
    logic              last;
    logic              ready;
    logic              ok;

    // A transfer happens on every edge where both sides agree.
    assign ok = valid && ready;

    modport master (output data, output valid, output last, input ready, input ok);
    modport slave  (input data, input valid, input last, input ok, output ready);
endinterface

// File: rtl/axis_pattern_source.sv
// axis_pattern_source: emits a packet of n_words transfers whose subwords
// count up from 0 (subword k of a word = base + k), ending in last, with
// optional LFSR-driven valid gaps.
//   clk, reset (sync, active-high)
//   start, n_words, gap_en : packet request, sampled only in IDLE
//   busy                   : high while a packet is in progress
//   done                   : one-cycle pulse after the packet completes
//   data_out               : Axis_If master (data/valid/last out, ready in)
module axis_pattern_source #(
    parameter int unsigned DWIDTH    = 48,
    parameter int unsigned WORD_SIZE = 12,
    parameter int unsigned LEN_WIDTH = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] n_words,
    input  logic                 gap_en,
    output logic                 busy,
    output logic                 done,
    Axis_If.master               data_out
);
    localparam int unsigned N_SUB = DWIDTH / WORD_SIZE;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic                   valid_q, valid_d;
    logic                   last_q, last_d;
    logic [DWIDTH-1:0]      data_q, data_d;
    logic [WORD_SIZE-1:0]   sub_cnt_q, sub_cnt_d;
    logic [LEN_WIDTH-1:0]   words_left_q, words_left_d;
    logic [15:0]            lfsr_q, lfsr_d;
    logic                   gap_en_q, gap_en_d;
    logic                   done_q, done_d;
    logic                   zero_pend_q, zero_pend_d;
    logic                   final_ok_c;

    // Word whose subword k is base + k (mod 2^WORD_SIZE).
    function automatic logic [DWIDTH-1:0] pattern(input logic [WORD_SIZE-1:0] base);
        logic [DWIDTH-1:0] w;
        w = '0;
        for (int unsigned k = 0; k < N_SUB; k++) begin
            w[k*WORD_SIZE +: WORD_SIZE] = base + WORD_SIZE'(k);
        end
        return w;
    endfunction

    // 16-bit Fibonacci LFSR, taps 16,14,13,11.
    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    assign final_ok_c = (state_q == RUN) && data_out.ok && last_q;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start && (n_words != '0)) state_d = RUN;
            RUN:     if (final_ok_c) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values for the registered outputs and datapath.
    always_comb begin
        valid_d      = valid_q;
        last_d       = last_q;
        data_d       = data_q;
        sub_cnt_d    = sub_cnt_q;
        words_left_d = words_left_q;
        lfsr_d       = lfsr_q;
        gap_en_d     = gap_en_q;
        done_d       = 1'b0;
        zero_pend_d  = 1'b0;
        case (state_q)
            IDLE: begin
                // A zero-length request completes one cycle after acceptance.
                done_d = zero_pend_q;
                if (start) begin
                    sub_cnt_d    = '0;
                    words_left_d = n_words;
                    gap_en_d     = gap_en;
                    data_d       = pattern('0);
                    if (n_words != '0) begin
                        valid_d = gap_en ? lfsr_q[0] : 1'b1;
                        last_d  = valid_d && (n_words == LEN_WIDTH'(1));
                    end else begin
                        zero_pend_d = 1'b1;
                    end
                end
            end
            RUN: begin
                lfsr_d = lfsr_step(lfsr_q);
                if (data_out.ok) begin
                    words_left_d = words_left_q - LEN_WIDTH'(1);
                    if (last_q) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        sub_cnt_d = sub_cnt_q + WORD_SIZE'(N_SUB);
                        data_d    = pattern(sub_cnt_d);
                        valid_d   = gap_en_q ? lfsr_q[0] : 1'b1;
                        last_d    = valid_d && (words_left_d == LEN_WIDTH'(1));
                    end
                end else if (!valid_q) begin
                    // Only an idle slot may re-evaluate; an offered word is held.
                    valid_d = gap_en_q ? lfsr_q[0] : 1'b1;
                    last_d  = valid_d && (words_left_q == LEN_WIDTH'(1));
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q      <= 1'b0;
            last_q       <= 1'b0;
            data_q       <= '0;
            sub_cnt_q    <= '0;
            words_left_q <= '0;
            lfsr_q       <= LFSR_SEED;
            gap_en_q     <= 1'b0;
            done_q       <= 1'b0;
            zero_pend_q  <= 1'b0;
        end else begin
            valid_q      <= valid_d;
            last_q       <= last_d;
            data_q       <= data_d;
            sub_cnt_q    <= sub_cnt_d;
            words_left_q <= words_left_d;
            lfsr_q       <= lfsr_d;
            gap_en_q     <= gap_en_d;
            done_q       <= done_d;
            zero_pend_q  <= zero_pend_d;
        end
    end

    assign data_out.data  = data_q;
    assign data_out.valid = valid_q;
    assign data_out.last  = last_q;
    assign busy           = (state_q == RUN);
    assign done           = done_q;
endmodule

// File: tb/tb_axis_pattern_source.sv
// Self-checking bench for axis_pattern_source: table of packet vectors run
// back to back, plus directed sequences for reset, zero length and abort.
module tb_axis_pattern_source;
    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] n_words;
    logic        gap_en;
    logic        ready;
    logic        busy;
    logic        done;

    int n_tests;
    int n_fail;

    Axis_If #(.DWIDTH(48)) axis ();
    assign axis.ready = ready;

    axis_pattern_source #(
        .DWIDTH(48), .WORD_SIZE(12), .LEN_WIDTH(16), .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .n_words(n_words),
        .gap_en(gap_en), .busy(busy), .done(done), .data_out(axis)
    );

    always #5 clk = ~clk;

    typedef struct {
        int n;          // packet length
        bit gap;        // gap_en
        bit rnd;        // random ready
        int poke;       // loop cycle at which start is re-pulsed (-1: never)
        bit exp_dense;  // expect one transfer per cycle, no idle cycles
        bit exp_gaps;   // expect at least one idle cycle
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [47:0] exp_word(input int base);
        logic [47:0] w;
        for (int k = 0; k < 4; k++) w[k*12 +: 12] = 12'(base + k);
        return w;
    endfunction

    // Entered at a negedge; leaves at the negedge of the done cycle.
    task automatic run_pkt(input vec_t v);
        int xfers = 0;
        int idle = 0;
        int cyc = 0;
        int lasts = 0;
        int sub = 0;
        bit prev_stall = 0;
        bit finished = 0;
        logic [47:0] pdata = '0;
        logic plast = 0;
        start = 1; n_words = 16'(v.n); gap_en = v.gap; ready = 1;
        @(negedge clk);
        start = 0;
        while (!finished && cyc < v.n * 8 + 64) begin
            ready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (cyc == v.poke) begin start = 1; n_words = 16'd2; end
            else start = 0;
            check("busy_in_pkt", 64'(busy), 64'(1));
            check("done_in_pkt", 64'(done), 64'(0));
            if (prev_stall) begin
                check("hold_valid", 64'(axis.valid), 64'(1));
                check("hold_data", 64'(axis.data), 64'(pdata));
                check("hold_last", 64'(axis.last), 64'(plast));
            end
            if (axis.valid) begin
                check("data", 64'(axis.data), 64'(exp_word(sub)));
                if (xfers == 0) check("word0", 64'(axis.data), 64'(48'h003002001000));
                if (ready) begin
                    xfers++;
                    check("last", 64'(axis.last), 64'(xfers == v.n));
                    sub += 4;
                    if (axis.last) begin lasts++; finished = 1; end
                end
            end else begin
                idle++;
            end
            prev_stall = axis.valid && !ready;
            pdata = axis.data;
            plast = axis.last;
            cyc++;
            @(negedge clk);
        end
        start = 0;
        check("pkt_finished", 64'(finished), 64'(1));
        check("xfer_count", 64'(xfers), 64'(v.n));
        check("last_count", 64'(lasts), 64'(1));
        check("done_pulse", 64'(done), 64'(1));
        check("busy_fall", 64'(busy), 64'(0));
        check("valid_fall", 64'(axis.valid), 64'(0));
        if (v.exp_dense) begin
            check("no_gaps", 64'(idle), 64'(0));
            check("pkt_cycles", 64'(cyc), 64'(v.n));
        end
        if (v.exp_gaps) check("some_gaps", 64'(idle > 0), 64'(1));
    endtask

    vec_t vecs[6];

    initial begin
        int cnt;
        vec_t tail;
        n_tests = 0; n_fail = 0;
        clk = 0; reset = 1; start = 0; n_words = 0; gap_en = 0; ready = 1;

        vecs[0] = '{n: 4,    gap: 0, rnd: 0, poke: -1, exp_dense: 1, exp_gaps: 0};
        vecs[1] = '{n: 4,    gap: 0, rnd: 1, poke: -1, exp_dense: 0, exp_gaps: 0};
        vecs[2] = '{n: 1,    gap: 0, rnd: 0, poke: -1, exp_dense: 1, exp_gaps: 0};
        vecs[3] = '{n: 6,    gap: 0, rnd: 0, poke: 2,  exp_dense: 1, exp_gaps: 0};
        vecs[4] = '{n: 400,  gap: 1, rnd: 0, poke: -1, exp_dense: 0, exp_gaps: 1};
        vecs[5] = '{n: 1100, gap: 1, rnd: 1, poke: -1, exp_dense: 0, exp_gaps: 0};

        // Reset state, with a start that reset must override.
        repeat (2) @(negedge clk);
        start = 1; n_words = 16'd3;
        @(negedge clk);
        start = 0;
        check("rst_valid", 64'(axis.valid), 64'(0));
        check("rst_last", 64'(axis.last), 64'(0));
        check("rst_data", 64'(axis.data), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        reset = 0;
        @(negedge clk);
        check("rst_start_busy", 64'(busy), 64'(0));
        check("rst_start_valid", 64'(axis.valid), 64'(0));

        // Zero-length request: done at T+2, nothing else.
        start = 1; n_words = 16'd0; gap_en = 0;
        @(negedge clk);
        start = 0;
        check("zero_done_t1", 64'(done), 64'(0));
        check("zero_busy_t1", 64'(busy), 64'(0));
        check("zero_valid_t1", 64'(axis.valid), 64'(0));
        @(negedge clk);
        check("zero_done_t2", 64'(done), 64'(1));
        check("zero_busy_t2", 64'(busy), 64'(0));
        check("zero_valid_t2", 64'(axis.valid), 64'(0));
        @(negedge clk);
        check("zero_done_t3", 64'(done), 64'(0));

        // Table of packets, each started in the previous done cycle.
        foreach (vecs[i]) run_pkt(vecs[i]);

        // Abort after 3 of 10 transfers.
        start = 1; n_words = 16'd10; gap_en = 0; ready = 1;
        @(negedge clk);
        start = 0;
        cnt = 0;
        for (int c = 0; c < 20 && cnt < 3; c++) begin
            if (axis.valid && ready) cnt++;
            @(negedge clk);
        end
        check("abort_progress", 64'(cnt), 64'(3));
        reset = 1;
        @(negedge clk);
        reset = 0;
        check("abort_valid", 64'(axis.valid), 64'(0));
        check("abort_last", 64'(axis.last), 64'(0));
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_done", 64'(done), 64'(0));
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("abort_no_done", 64'(done), 64'(0));
            check("abort_no_valid", 64'(axis.valid), 64'(0));
        end
        tail = '{n: 2, gap: 0, rnd: 0, poke: -1, exp_dense: 1, exp_gaps: 0};
        run_pkt(tail);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end
endmodule
